// File: rtl/perf_monitor_if.sv
// Signal bundle between a CPU-side observer/driver and the performance monitor.
// The master drives the observed CPU signals, start and the readout select;
// the slave (the monitor) returns the selected count and status flags.
interface perf_monitor_if #(
    parameter int PC_WIDTH  = 10,
    parameter int CNT_WIDTH = 32,
    parameter int N_EXT     = 2
);
    localparam int NUM_CNT = 4 + N_EXT;
    localparam int SEL_W   = $clog2(NUM_CNT);
    localparam int EXT_W   = (N_EXT > 0) ? N_EXT : 1;

    logic                 start;
    logic [PC_WIDTH-1:0]  pc;
    logic                 read;
    logic                 write;
    logic                 halted;
    logic [EXT_W-1:0]     ext_event;
    logic [SEL_W-1:0]     sel;
    logic [CNT_WIDTH-1:0] count_out;
    logic [NUM_CNT-1:0]   overflow;
    logic                 running;
    logic                 done;

    modport master (
        output start, pc, read, write, halted, ext_event, sel,
        input  count_out, overflow, running, done
    );

    modport slave (
        input  start, pc, read, write, halted, ext_event, sel,
        output count_out, overflow, running, done
    );
endinterface

// File: rtl/perf_monitor.sv
// Performance monitor: counts cycles, retired instructions, memory reads,
// memory writes and N_EXT generic events over one program run (start..halt).
// Counters saturate with sticky overflow flags; values are read back through
// a registered select port with one cycle of latency.
module perf_monitor #(
    parameter int PC_WIDTH  = 10,
    parameter int CNT_WIDTH = 32,
    parameter int N_EXT     = 2
) (
    input  logic          clk,
    input  logic          reset,
    perf_monitor_if.slave bus
);
    localparam int NUM_CNT = 4 + N_EXT;
    localparam int SEL_W   = $clog2(NUM_CNT);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_reg;
    state_t               state_next;
    logic [CNT_WIDTH-1:0] cnt_reg [NUM_CNT];
    logic [NUM_CNT-1:0]   ovf_reg;
    logic [NUM_CNT-1:0]   inc;
    logic [PC_WIDTH-1:0]  last_pc_reg;
    logic                 first_flag_reg;
    logic [CNT_WIDTH-1:0] count_out_reg;
    logic [CNT_WIDTH-1:0] read_val;
    logic                 running_reg;
    logic                 done_reg;

    // Per-counter increment requests for the current cycle (only honoured in RUN).
    assign inc[0] = 1'b1;
    assign inc[1] = first_flag_reg || (bus.pc != last_pc_reg);
    assign inc[2] = bus.read;
    assign inc[3] = bus.write;

    generate
        for (genvar gi = 0; gi < N_EXT; gi++) begin : g_ext_inc
            assign inc[4+gi] = bus.ext_event[gi];
        end
    endgenerate

    // Next-state logic: start always (re)arms a run and beats halted.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.start) state_next = RUN;
            RUN: begin
                if (bus.start)       state_next = RUN;
                else if (bus.halted) state_next = DONE;
            end
            DONE:    if (bus.start) state_next = RUN;
            default: state_next = IDLE;
        endcase
    end

    // State register plus registered status flags that mirror it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            running_reg <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            running_reg <= (state_next == RUN);
            done_reg    <= (state_next == DONE);
        end
    end

    // Instruction-retire tracking: a new pc value (or the first RUN cycle) retires one.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_pc_reg    <= '0;
            first_flag_reg <= 1'b1;
        end else if (bus.start) begin
            first_flag_reg <= 1'b1;
        end else if (state_reg == RUN) begin
            last_pc_reg    <= bus.pc;
            first_flag_reg <= 1'b0;
        end
    end

    // Saturating counters with sticky overflow; start clears them from any state.
    always_ff @(posedge clk) begin
        if (reset || bus.start) begin
            for (int i = 0; i < NUM_CNT; i++) begin
                cnt_reg[i] <= '0;
            end
            ovf_reg <= '0;
        end else if (state_reg == RUN) begin
            for (int i = 0; i < NUM_CNT; i++) begin
                if (inc[i]) begin
                    if (cnt_reg[i] == CNT_MAX) begin
                        ovf_reg[i] <= 1'b1;
                    end else begin
                        cnt_reg[i] <= cnt_reg[i] + 1'b1;
                    end
                end
            end
        end
    end

    // Readout mux; out-of-range selects yield zero.
    always_comb begin
        read_val = '0;
        for (int i = 0; i < NUM_CNT; i++) begin
            if (bus.sel == SEL_W'(i)) begin
                read_val = cnt_reg[i];
            end
        end
    end

    // Registered readout: shows counter contents before this edge's increment.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_out_reg <= '0;
        end else begin
            count_out_reg <= read_val;
        end
    end

    assign bus.count_out = count_out_reg;
    assign bus.overflow  = ovf_reg;
    assign bus.running   = running_reg;
    assign bus.done      = done_reg;
endmodule
